// File: rtl/fpu_pkg.sv
// Shared types and defaults for the FPU sequencer slice.
//   fpu_op_t       : FPU arithmetic op codes as driven by the main decoder
//   fpseq_state_t  : sequencer FSM states
//   *_DEF          : default latencies and latency-counter width
//   is_arith_code  : true for the codes the sequencer accepts
package fpu_pkg;

    typedef enum logic [3:0] {
        FPU_ADD = 4'h0,
        FPU_SUB = 4'h1,
        FPU_MUL = 4'h2,
        FPU_DIV = 4'h3
    } fpu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_WB
    } fpseq_state_t;

    localparam int LAT_ADD_DEF = 2;
    localparam int LAT_MUL_DEF = 4;
    localparam int LAT_DIV_DEF = 16;
    localparam int CW_DEF      = 5;

    // Codes 0..3 are the only arithmetic ops; everything else is illegal.
    function automatic logic is_arith_code(input logic [3:0] code);
        return (code[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// Latency lookup: maps an FPU op to the value loaded into the sequencer's
// down-counter on accept (latency minus one).
//   op      in   fpu_op_t  op being accepted
//   lat_m1  out  CW        counter load value
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int LAT_ADD = LAT_ADD_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF,
    parameter int CW      = CW_DEF
) (
    input  fpu_op_t         op,
    output logic [CW-1:0]   lat_m1
);

    always_comb begin
        lat_m1 = '0;
        case (op)
            FPU_ADD: lat_m1 = CW'(LAT_ADD - 1);
            FPU_SUB: lat_m1 = CW'(LAT_ADD - 1);
            FPU_MUL: lat_m1 = CW'(LAT_MUL - 1);
            FPU_DIV: lat_m1 = CW'(LAT_DIV - 1);
            default: lat_m1 = '0;
        endcase
    end

endmodule

// File: rtl/fpu_sequencer.sv
// Multi-cycle sequencer for the FPU datapath behind the single-cycle core.
// Accepts one FP arithmetic op, stalls the core for the op's fixed latency,
// then issues a single FP register-file write. Keeps a sticky divide-by-zero
// flag.
//   clk, reset            core clock; synchronous active-low reset
//   fp_op_valid           current instruction is FPU arithmetic
//   fpu_control, fp_dst   decoder op code and destination register
//   fpu_result, fpu_dbz   datapath result / div-by-zero, valid in WB
//   clr_flags             clear sticky flags
//   stall                 hold PC / suppress core state updates
//   fpu_start             1-cycle operand-latch pulse for the FPU
//   fpu_op, fp_waddr      latched op and destination, held between ops
//   fp_we, fp_wdata       FP register-file write port (WB only)
//   busy                  FSM not idle
//   illegal_op            1-cycle pulse on an unknown op code
//   dbz_flag              sticky divide-by-zero flag
//
// state  | meaning
// S_IDLE | waiting for an FP op; accepts in the same cycle it is presented
// S_BUSY | counting down the op latency, core stalled
// S_WB   | result written back, core released
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int LAT_ADD = LAT_ADD_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fp_op_valid,
    input  logic [3:0]  fpu_control,
    input  logic [4:0]  fp_dst,
    input  logic [31:0] fpu_result,
    input  logic        fpu_dbz,
    input  logic        clr_flags,
    output logic        stall,
    output logic        fpu_start,
    output logic [3:0]  fpu_op,
    output logic        fp_we,
    output logic [4:0]  fp_waddr,
    output logic [31:0] fp_wdata,
    output logic        busy,
    output logic        illegal_op,
    output logic        dbz_flag
);

    fpseq_state_t  state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_load;
    logic          in_idle;
    logic          in_busy;
    logic          in_wb;
    logic          arith;
    logic          accept;
    logic          dbz_set;

    fpu_lat_lut #(
        .LAT_ADD (LAT_ADD),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV),
        .CW      (CW)
    ) u_lat_lut (
        .op     (fpu_op_t'(fpu_control)),
        .lat_m1 (cnt_load)
    );

    // Every combinational output is qualified by reset so that nothing is
    // asserted while reset is held, including an aborted op sitting in WB.
    always_comb begin
        in_idle    = reset && (state == S_IDLE);
        in_busy    = reset && (state == S_BUSY);
        in_wb      = reset && (state == S_WB);
        arith      = is_arith_code(fpu_control);
        accept     = in_idle && fp_op_valid && arith;
        stall      = accept || in_busy;
        fpu_start  = accept;
        illegal_op = in_idle && fp_op_valid && !arith;
        busy       = in_busy || in_wb;
        fp_we      = in_wb;
        fp_wdata   = in_wb ? fpu_result : 32'h0;
        dbz_set    = in_wb && (fpu_op == FPU_DIV) && fpu_dbz;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            fpu_op   <= 4'h0;
            fp_waddr <= 5'h0;
            dbz_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        fpu_op   <= fpu_control;
                        fp_waddr <= fp_dst;
                        cnt      <= cnt_load;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_WB;
                end
                // fp_op_valid is still high here for the same instruction;
                // returning to IDLE without looking at it avoids a re-accept.
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // A set in the same cycle as a clear takes priority.
            if (dbz_set)
                dbz_flag <= 1'b1;
            else if (clr_flags)
                dbz_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
module tb_fpu_sequencer;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fp_op_valid;
    logic [3:0]  fpu_control;
    logic [4:0]  fp_dst;
    logic [31:0] fpu_result;
    logic        fpu_dbz;
    logic        clr_flags;
    logic        stall;
    logic        fpu_start;
    logic [3:0]  fpu_op;
    logic        fp_we;
    logic [4:0]  fp_waddr;
    logic [31:0] fp_wdata;
    logic        busy;
    logic        illegal_op;
    logic        dbz_flag;

    int n_vec = 0;
    int n_err = 0;
    int stall_cnt;

    fpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .fp_op_valid (fp_op_valid),
        .fpu_control (fpu_control),
        .fp_dst      (fp_dst),
        .fpu_result  (fpu_result),
        .fpu_dbz     (fpu_dbz),
        .clr_flags   (clr_flags),
        .stall       (stall),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .fp_we       (fp_we),
        .fp_waddr    (fp_waddr),
        .fp_wdata    (fp_wdata),
        .busy        (busy),
        .illegal_op  (illegal_op),
        .dbz_flag    (dbz_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later,
    // well away from the rising edge that closes the cycle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        fp_op_valid = 1'b1;
        fpu_control = 4'(FPU_ADD);
        fp_dst      = 5'd0;
        fpu_result  = 32'h0;
        fpu_dbz     = 1'b0;
        clr_flags   = 1'b0;

        // 1. reset held 3 cycles with an ADD presented
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            #1;
            check("rst_stall", {31'b0, stall}, 32'd0);
            check("rst_fpu_start", {31'b0, fpu_start}, 32'd0);
            check("rst_fp_we", {31'b0, fp_we}, 32'd0);
            check("rst_busy", {31'b0, busy}, 32'd0);
            if (c > 0) begin
                check("rst_dbz_flag", {31'b0, dbz_flag}, 32'd0);
                check("rst_fpu_op", {28'b0, fpu_op}, 32'd0);
                check("rst_fp_waddr", {27'b0, fp_waddr}, 32'd0);
            end
        end

        // 2. ADD, fd=5: stall cycles 0-1, write in cycle 2, no re-accept
        next_cycle();
        reset       = 1'b1;
        fp_op_valid = 1'b1;
        fpu_control = 4'(FPU_ADD);
        fp_dst      = 5'd5;
        fpu_result  = 32'h4040_0000;
        #1;
        check("add_c0_stall", {31'b0, stall}, 32'd1);
        check("add_c0_start", {31'b0, fpu_start}, 32'd1);
        check("add_c0_we", {31'b0, fp_we}, 32'd0);
        next_cycle();
        #1;
        check("add_c1_stall", {31'b0, stall}, 32'd1);
        check("add_c1_start", {31'b0, fpu_start}, 32'd0);
        check("add_c1_busy", {31'b0, busy}, 32'd1);
        check("add_c1_we", {31'b0, fp_we}, 32'd0);
        check("add_c1_wdata", fp_wdata, 32'h0);
        next_cycle();
        #1;
        check("add_c2_stall", {31'b0, stall}, 32'd0);
        check("add_c2_we", {31'b0, fp_we}, 32'd1);
        check("add_c2_waddr", {27'b0, fp_waddr}, 32'd5);
        check("add_c2_wdata", fp_wdata, 32'h4040_0000);
        check("add_c2_start", {31'b0, fpu_start}, 32'd0);
        next_cycle();
        fp_op_valid = 1'b0;
        #1;
        check("add_c3_busy", {31'b0, busy}, 32'd0);
        check("add_c3_we", {31'b0, fp_we}, 32'd0);
        check("add_c3_wdata", fp_wdata, 32'h0);
        check("add_c3_stall", {31'b0, stall}, 32'd0);

        // 3. DIV, fd=31, div-by-zero in WB with a simultaneous clear
        stall_cnt = 0;
        for (int c = 0; c <= 16; c++) begin
            next_cycle();
            fp_op_valid = 1'b1;
            fpu_control = 4'(FPU_DIV);
            fp_dst      = 5'd31;
            fpu_result  = 32'h7F80_0000;
            fpu_dbz     = (c == 16);
            clr_flags   = (c == 16);
            #1;
            if (stall) stall_cnt++;
            check($sformatf("div_c%0d_stall", c), {31'b0, stall}, {31'b0, (c < 16)});
            check($sformatf("div_c%0d_we", c), {31'b0, fp_we}, {31'b0, (c == 16)});
        end
        check("div_stall_total", stall_cnt, 32'd16);
        check("div_waddr", {27'b0, fp_waddr}, 32'd31);
        check("div_wdata", fp_wdata, 32'h7F80_0000);
        check("div_flag_before_set", {31'b0, dbz_flag}, 32'd0);
        next_cycle();
        fp_op_valid = 1'b0;
        fpu_dbz     = 1'b0;
        clr_flags   = 1'b0;
        #1;
        check("div_flag_c17", {31'b0, dbz_flag}, 32'd1);
        check("div_c17_busy", {31'b0, busy}, 32'd0);
        next_cycle();
        clr_flags = 1'b1;
        #1;
        check("div_flag_clr_cycle", {31'b0, dbz_flag}, 32'd1);
        next_cycle();
        clr_flags = 1'b0;
        #1;
        check("div_flag_cleared", {31'b0, dbz_flag}, 32'd0);

        // 4. MUL fd=2 then SUB fd=3 issued immediately after MUL's WB
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            fp_op_valid = (c < 8);
            fpu_control = (c < 5) ? 4'(FPU_MUL) : 4'(FPU_SUB);
            fp_dst      = (c < 5) ? 5'd2 : 5'd3;
            fpu_result  = (c < 5) ? 32'h4100_0000 : 32'hC000_0000;
            #1;
            check($sformatf("ms_c%0d_we", c), {31'b0, fp_we}, {31'b0, (c == 4 || c == 7)});
            check($sformatf("ms_c%0d_start", c), {31'b0, fpu_start}, {31'b0, (c == 0 || c == 5)});
            check($sformatf("ms_c%0d_stall", c), {31'b0, stall},
                  {31'b0, ((c <= 3) || (c == 5) || (c == 6))});
            if (c >= 1 && c <= 5)
                check($sformatf("ms_c%0d_op_mul", c), {28'b0, fpu_op}, 32'(FPU_MUL));
            if (c >= 6)
                check($sformatf("ms_c%0d_op_sub", c), {28'b0, fpu_op}, 32'(FPU_SUB));
            if (c == 4) begin
                check("ms_mul_waddr", {27'b0, fp_waddr}, 32'd2);
                check("ms_mul_wdata", fp_wdata, 32'h4100_0000);
            end
            if (c == 7) begin
                check("ms_sub_waddr", {27'b0, fp_waddr}, 32'd3);
                check("ms_sub_wdata", fp_wdata, 32'hC000_0000);
            end
        end

        // 5a. unknown code 4'h7
        next_cycle();
        fp_op_valid = 1'b1;
        fpu_control = 4'h7;
        #1;
        check("ill_pulse", {31'b0, illegal_op}, 32'd1);
        check("ill_stall", {31'b0, stall}, 32'd0);
        check("ill_start", {31'b0, fpu_start}, 32'd0);
        next_cycle();
        fp_op_valid = 1'b0;
        #1;
        check("ill_pulse_gone", {31'b0, illegal_op}, 32'd0);
        check("ill_busy", {31'b0, busy}, 32'd0);

        // 5b. DIV aborted by reset in cycle 8
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            fp_op_valid = 1'b1;
            fpu_control = 4'(FPU_DIV);
            fp_dst      = 5'd9;
            fpu_dbz     = 1'b1;
            reset       = (c != 8);
            #1;
            check($sformatf("abort_c%0d_stall", c), {31'b0, stall}, {31'b0, (c < 8)});
            check($sformatf("abort_c%0d_we", c), {31'b0, fp_we}, 32'd0);
        end
        for (int c = 9; c < 30; c++) begin
            next_cycle();
            reset       = 1'b1;
            fp_op_valid = 1'b0;
            #1;
            check($sformatf("abort_c%0d_we", c), {31'b0, fp_we}, 32'd0);
            check($sformatf("abort_c%0d_busy", c), {31'b0, busy}, 32'd0);
        end
        check("abort_fpu_op", {28'b0, fpu_op}, 32'd0);
        check("abort_dbz_flag", {31'b0, dbz_flag}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
